// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory serving one valid/ready request at a time.
// A request is captured in IDLE, served after LATENCY cycles with a one-cycle ready pulse.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byte_enable,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [29:0] idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] mem [DEPTH_WORDS];
   logic        in_range;
   logic [AW-1:0] widx;
   assign in_range = {2'b00, idx_q} < 32'(DEPTH_WORDS);
   assign widx     = idx_q[AW-1:0];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      case (state_q)
         IDLE: if (valid) begin
            idx_d   = addr[31:2];
            wdata_d = wdata;
            be_d    = byte_enable;
            cnt_d   = 4'(LATENCY - 1);
            state_d = (LATENCY > 1) ? BUSY : RESP;
         end
         BUSY: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q <= 4'd1) ? RESP : BUSY;
         end
         default: state_d = IDLE;
      endcase
   end
   // Store commits on the edge that ends RESP; a reset on that edge wins.
   always_ff @(posedge clk) begin
      if (rst_n && state_q == RESP && in_range)
         for (int i = 0; i < 4; i++)
            if (be_q[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
   end
   assign ready = state_q == RESP;
   assign err   = ready && !in_range;
   assign rdata = (ready && in_range && be_q == 4'b0000) ? mem[widx] : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a LATENCY=2 and a LATENCY=1 responder.
module tb_dmem_responder;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        valid = 1'b0, valid1 = 1'b0;
   logic [31:0] addr = '0, wdata = '0, addr1 = '0, wdata1 = '0;
   logic [3:0]  be = '0, be1 = '0;
   logic        ready, err, ready1, err1;
   logic [31:0] rdata, rdata1;
   int          total = 0, bad = 0;
   logic [31:0] rd;
   logic        e, ra;
   int          n, pulses, p1, p2;
   always #5 clk = ~clk;
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .addr(addr), .wdata(wdata),
      .byte_enable(be), .ready(ready), .rdata(rdata), .err(err));
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .valid(valid1), .addr(addr1), .wdata(wdata1),
      .byte_enable(be1), .ready(ready1), .rdata(rdata1), .err(err1));
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // One request on the LATENCY=2 unit; n counts edges from acceptance to ready.
   task automatic xact(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] r, output logic ee, output int cnt, output logic after);
      valid = 1'b1; addr = a; be = b; wdata = d; cnt = 0;
      do begin step; cnt++; end while (!ready && cnt < 20);
      r = rdata; ee = err;
      valid = 1'b0;
      step;
      after = ready;
   endtask
   task automatic xact1(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] r, output int cnt);
      valid1 = 1'b1; addr1 = a; be1 = b; wdata1 = d; cnt = 0;
      do begin step; cnt++; end while (!ready1 && cnt < 20);
      r = rdata1;
      valid1 = 1'b0;
      step;
   endtask
   initial begin
      step; step;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready1", 32'(ready1), 32'd0);
      rst_n = 1'b1;
      xact(32'h10, 4'b1111, 32'hDEADBEEF, rd, e, n, ra);
      chk("st_lat", n, 2);
      chk("st_rdata", rd, 32'h0);
      chk("st_err", 32'(e), 32'd0);
      chk("st_one_pulse", 32'(ra), 32'd0);
      xact(32'h10, 4'b0000, 32'h0, rd, e, n, ra);
      chk("ld_lat", n, 2);
      chk("ld_rdata", rd, 32'hDEADBEEF);
      chk("ld_err", 32'(e), 32'd0);
      xact(32'h10, 4'b0011, 32'h00001234, rd, e, n, ra);
      xact(32'h10, 4'b0000, 32'h0, rd, e, n, ra);
      chk("partial", rd, 32'hDEAD1234);
      xact(32'h20, 4'b1111, 32'h55555555, rd, e, n, ra);
      xact(32'h24, 4'b1111, 32'h00000000, rd, e, n, ra);
      valid = 1'b1; addr = 32'h21; be = 4'b1110; wdata = 32'hCCBBAA00;
      pulses = 0; p1 = 0; p2 = 0;
      for (int c = 1; c <= 8; c++) begin
         step;
         if (ready) begin
            pulses++;
            if (pulses == 1) begin
               p1 = c; addr = 32'h24; be = 4'b0001; wdata = 32'h000000DD;
            end else begin
               p2 = c; valid = 1'b0;
            end
         end
      end
      valid = 1'b0;
      chk("split_pulses", pulses, 2);
      chk("split_gap", p2 - p1, 3);
      xact(32'h20, 4'b0000, 32'h0, rd, e, n, ra);
      chk("split_w20", rd, 32'hCCBBAA55);
      xact(32'h24, 4'b0000, 32'h0, rd, e, n, ra);
      chk("split_w24", rd, 32'h000000DD);
      xact(32'h0, 4'b1111, 32'h01020304, rd, e, n, ra);
      xact(32'h1000, 4'b0000, 32'h0, rd, e, n, ra);
      chk("oor_ld_lat", n, 2);
      chk("oor_ld_rdata", rd, 32'h0);
      chk("oor_ld_err", 32'(e), 32'd1);
      xact(32'h1000, 4'b1111, 32'hA5A5A5A5, rd, e, n, ra);
      chk("oor_st_err", 32'(e), 32'd1);
      chk("oor_st_rdata", rd, 32'h0);
      xact(32'h0, 4'b0000, 32'h0, rd, e, n, ra);
      chk("oor_w0_kept", rd, 32'h01020304);
      xact(32'h10, 4'b0000, 32'h0, rd, e, n, ra);
      chk("oor_w10_kept", rd, 32'hDEAD1234);
      valid = 1'b1; addr = 32'h30; be = 4'b1111; wdata = 32'h11111111;
      step;
      valid = 1'b0; addr = 32'h40; wdata = 32'hFFFFFFFF;
      n = 1;
      while (!ready && n < 20) begin step; n++; end
      chk("abort_lat", n, 2);
      step;
      xact(32'h30, 4'b0000, 32'h0, rd, e, n, ra);
      chk("abort_commit", rd, 32'h11111111);
      valid = 1'b1; addr = 32'h30; be = 4'b1111; wdata = 32'h22222222;
      step;
      rst_n = 1'b0; valid = 1'b0;
      step;
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         step;
         if (ready) pulses++;
      end
      chk("rst_drop_pulses", pulses, 0);
      xact(32'h30, 4'b0000, 32'h0, rd, e, n, ra);
      chk("rst_drop_mem", rd, 32'h11111111);
      xact1(32'h8, 4'b1111, 32'hCAFEF00D, rd, n);
      chk("l1_st_lat", n, 1);
      valid1 = 1'b1; addr1 = 32'h8; be1 = 4'b0000; wdata1 = 32'h0;
      pulses = 0; p1 = 0; p2 = 0; rd = '0;
      for (int c = 1; c <= 8; c++) begin
         step;
         if (ready1) begin
            pulses++;
            if (pulses == 1) begin p1 = c; rd = rdata1; end
            p2 = c;
         end
      end
      valid1 = 1'b0;
      chk("l1_first", p1, 1);
      chk("l1_pulses", pulses, 4);
      chk("l1_span", p2 - p1, 6);
      chk("l1_rdata", rd, 32'hCAFEF00D);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, giving cycles from request acceptance to ready (legal range 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 valid  input  1  request present; held by the initiator until ready.
REQ-006 addr  input  32  byte address; addr[1:0] ignored; word index = addr[31:2].
REQ-007 wdata  input  32  store data, byte lanes aligned to byte_enable.
REQ-008 byte_enable  input  4  lane write mask; nonzero = store, 4'b0000 = load.
REQ-009 ready  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  load data, valid only while ready=1.
REQ-011 err  output  1  out-of-range flag, valid only while ready=1.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-013 IDLE with valid=1 SHALL accept the request in cycle T, capturing addr, wdata and byte_enable into registers.
- Next state is BUSY if LATENCY>1, else RESP.
REQ-014 BUSY SHALL count down a wait counter loaded with LATENCY-1 at acceptance and enter RESP when the counter reaches 1.
- Net effect: RESP occupies cycle T+LATENCY.
REQ-015 RESP SHALL drive ready=1 for exactly one cycle, then return to IDLE.
REQ-016 A new request SHALL NOT be accepted in the RESP cycle, even though valid is still high.
REQ-017 A valid held high after RESP SHALL be accepted in the following IDLE cycle.
- Back-to-back requests complete every LATENCY+1 cycles.
REQ-018 Input changes during BUSY SHALL be ignored; only the captured request is served.
REQ-019 Deassertion of valid during BUSY SHALL NOT abort the transaction.
- ready still pulses.
- A captured store still commits.
REQ-020 Store SHALL write only the lanes where byte_enable[i]=1:
- mem[idx][8i+7:8i] <= wdata[8i+7:8i].
- Write commits at the clock edge ending the RESP cycle.
- Unselected lanes are unchanged.
REQ-021 Store response SHALL drive rdata=32'h0 with ready.
REQ-022 Load response SHALL drive rdata = full word mem[idx] as it stands at the RESP cycle.
REQ-023 rdata SHALL be 32'h0 whenever ready=0.
REQ-024 Word index >= DEPTH_WORDS SHALL be out of range:
- Store: no write.
- Load: rdata=0.
- Both: err=1 and ready still pulses at the normal latency.
REQ-025 err SHALL be 0 whenever ready=0.
REQ-026 Memory contents SHALL NOT be initialised by reset.
- Reads of never-written words are undefined; the bench writes before reading.

Reset
REQ-027 While rst_n=0 at a rising edge:
- state <= IDLE, counter <= 0 and the captured-request registers <= 0.
- ready=0, rdata=0 and err=0 from the next cycle.
REQ-028 Reset asserted during BUSY or RESP SHALL drop the pending request.
- No ready pulse.
- No memory write, provided the reset edge precedes the commit edge.
REQ-029 The first request SHALL be acceptable in the first cycle after rst_n returns to 1.

Verification
REQ-030 Full write then read, LATENCY=2:
- Store addr 0x10, be 4'b1111, wdata 0xDEADBEEF accepted at T -> ready=1 at T+2 only.
- Load addr 0x10 -> rdata=0xDEADBEEF, err=0 at its T+2.
REQ-031 Partial write:
- Word 0x10 holds 0xDEADBEEF; store be 4'b0011, wdata 0x00001234.
- Then load 0x10 -> rdata=0xDEAD1234.
REQ-032 Split access with valid held high throughout:
- Store addr 0x21, be 4'b1110, wdata 0xCCBBAA00; after its ready, addr changes to 0x24, be 4'b0001, wdata 0x000000DD.
- Required: exactly two ready pulses, three cycles apart.
- Required: load 0x20 -> 0xCCBBAAxx (lane 0 unchanged); load 0x24 low byte -> 0xDD.
REQ-033 Out of range, DEPTH_WORDS=1024:
- Load addr 0x1000 -> ready with rdata=0, err=1.
- Store addr 0x1000 -> ready with err=1, and no other word is modified.
REQ-034 Abort and reset:
- valid dropped one cycle after acceptance of store 0x30/0x11111111 -> ready still pulses; load 0x30 returns 0x11111111.
- rst_n=0 during BUSY of store 0x30/0x22222222 -> no ready pulse; load 0x30 still returns 0x11111111.
REQ-035 LATENCY=1 build:
- Load accepted at T -> ready at T+1.
- Continuous valid yields a ready every 2 cycles.
